// File: rtl/datapath_two_reg.sv
// Single-bus 32-bit CPU datapath slice: R2/R6, HI/LO, IR, Y, PC, MAR, MDR, 64-bit Z
// and a combinational ALU, all sharing one bus selected by a priority out-select encoder.
module datapath_two_reg #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             PCout,
  input  logic             Zlowout,
  input  logic             Zhighout,
  input  logic             MDRout,
  input  logic             R2out,
  input  logic             R6out,
  input  logic             R0out,
  input  logic             R1out,
  input  logic             R3out,
  input  logic             R4out,
  input  logic             R5out,
  input  logic             R7out,
  input  logic             R8out,
  input  logic             R9out,
  input  logic             R10out,
  input  logic             R11out,
  input  logic             R12out,
  input  logic             R13out,
  input  logic             R14out,
  input  logic             R15out,
  input  logic             LOout,
  input  logic             HIout,
  input  logic             Cout,
  input  logic             InPortout,
  input  logic             MARin,
  input  logic             Zlowin,
  input  logic             Zhighin,
  input  logic             PCin,
  input  logic             MDRin,
  input  logic             IRin,
  input  logic             Yin,
  input  logic             R2in,
  input  logic             R6in,
  input  logic             LOin,
  input  logic             HIin,
  input  logic             IncPC,
  input  logic             Read,
  input  logic             AND,
  input  logic [WIDTH-1:0] Mdatain,
  input  logic [4:0]       operation,
  output logic [31:0]      encoder_input
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic [4:0] {
    OP_ADD  = 5'd3,
    OP_SUB  = 5'd4,
    OP_AND  = 5'd5,
    OP_OR   = 5'd6,
    OP_ROR  = 5'd7,
    OP_ROL  = 5'd8,
    OP_SHR  = 5'd9,
    OP_SHRA = 5'd10,
    OP_SHL  = 5'd11,
    OP_MUL  = 5'd14,
    OP_DIV  = 5'd15,
    OP_NEG  = 5'd16,
    OP_NOT  = 5'd17
  } alu_op_e;

  typedef enum logic [4:0] {
    SRC_R2    = 5'd2,
    SRC_R6    = 5'd6,
    SRC_HI    = 5'd16,
    SRC_LO    = 5'd17,
    SRC_ZHIGH = 5'd18,
    SRC_ZLOW  = 5'd19,
    SRC_PC    = 5'd20,
    SRC_MDR   = 5'd21,
    SRC_C     = 5'd23
  } bus_src_e;

  logic [WIDTH-1:0]   r2, r6, hi, lo, ir, y, pc, mar, mdr;
  logic [2*WIDTH-1:0] z;
  logic [WIDTH-1:0]   bus;
  logic [2*WIDTH-1:0] c;
  logic [4:0]         sel_idx;
  logic               sel_valid;

  assign encoder_input = {8'h00, Cout, InPortout, MDRout, PCout, Zlowout, Zhighout, LOout, HIout,
                          R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                          R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};

  // Scanning from the top down leaves the lowest-numbered asserted select in sel_idx.
  always_comb begin
    sel_idx   = '0;
    sel_valid = 1'b0;
    for (int unsigned i = 32; i > 0; i--) begin
      if (encoder_input[i-1]) begin
        sel_idx   = 5'(i - 1);
        sel_valid = 1'b1;
      end
    end
  end

  always_comb begin
    bus = '0;
    if (sel_valid) begin
      case (sel_idx)
        SRC_R2:    bus = r2;
        SRC_R6:    bus = r6;
        SRC_HI:    bus = hi;
        SRC_LO:    bus = lo;
        SRC_ZHIGH: bus = z[2*WIDTH-1:WIDTH];
        SRC_ZLOW:  bus = z[WIDTH-1:0];
        SRC_PC:    bus = pc;
        SRC_MDR:   bus = mdr;
        SRC_C:     bus = {{(WIDTH-19){ir[18]}}, ir[18:0]};
        default:   bus = '0;
      endcase
    end
  end

  logic [WIDTH-1:0]        a, b;
  logic signed [WIDTH-1:0] a_s, b_s, quo, rem;
  logic [2*WIDTH-1:0]      dbl;
  logic [SW-1:0]           sh;

  assign a   = y;
  assign b   = bus;
  assign a_s = y;
  assign b_s = bus;
  assign sh  = bus[SW-1:0];

  always_comb begin
    c   = '0;
    dbl = '0;
    quo = '0;
    rem = '0;
    case (operation)
      OP_ADD:  c[WIDTH-1:0] = a + b;
      OP_SUB:  c[WIDTH-1:0] = a - b;
      OP_AND:  c[WIDTH-1:0] = a & b;
      OP_OR:   c[WIDTH-1:0] = a | b;
      OP_ROR: begin
        dbl          = {a, a} >> sh;
        c[WIDTH-1:0] = dbl[WIDTH-1:0];
      end
      OP_ROL: begin
        dbl          = {a, a} << sh;
        c[WIDTH-1:0] = dbl[2*WIDTH-1:WIDTH];
      end
      OP_SHR:  c[WIDTH-1:0] = a >> sh;
      OP_SHRA: c[WIDTH-1:0] = a_s >>> sh;
      OP_SHL:  c[WIDTH-1:0] = a << sh;
      OP_MUL:  c = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
      OP_DIV: begin
        // The two undefined quotients are pinned explicitly rather than left to the divider.
        if (b == '0) begin
          quo = '1;
          rem = a_s;
        end else if (a == {1'b1, {(WIDTH-1){1'b0}}} && b == '1) begin
          quo = a_s;
          rem = '0;
        end else begin
          quo = a_s / b_s;
          rem = a_s % b_s;
        end
        c = {rem, quo};
      end
      OP_NEG:  c[WIDTH-1:0] = '0 - b;
      OP_NOT:  c[WIDTH-1:0] = ~b;
      default: c = '0;
    endcase
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      r2  <= '0;
      r6  <= '0;
      hi  <= '0;
      lo  <= '0;
      ir  <= '0;
      y   <= '0;
      pc  <= '0;
      mar <= '0;
      mdr <= '0;
      z   <= '0;
    end else begin
      if (R2in)  r2  <= bus;
      if (R6in)  r6  <= bus;
      if (HIin)  hi  <= bus;
      if (LOin)  lo  <= bus;
      if (IRin)  ir  <= bus;
      if (Yin)   y   <= bus;
      if (MARin) mar <= bus;
      if (MDRin) mdr <= Read ? Mdatain : bus;
      if (PCin && IncPC) pc <= pc + {{(WIDTH-1){1'b0}}, 1'b1};
      else if (PCin)     pc <= bus;
      if (Zlowin)  z[WIDTH-1:0]         <= c[WIDTH-1:0];
      if (Zhighin) z[2*WIDTH-1:WIDTH]   <= c[2*WIDTH-1:WIDTH];
    end
  end

  logic unused_bits;
  assign unused_bits = ^{AND, ir[WIDTH-1:19], mar};

endmodule

// File: tb/tb_datapath_two_reg.sv
// Directed plus randomized checks of datapath_two_reg against an arithmetic reference model.
module tb_datapath_two_reg;

  logic        Clock = 1'b0;
  logic        Clear = 1'b1;
  logic        PCout, Zlowout, Zhighout, MDRout, LOout, HIout, Cout, InPortout;
  logic [15:0] rout;
  logic        MARin, Zlowin, Zhighin, PCin, MDRin, IRin, Yin, R2in, R6in, LOin, HIin;
  logic        IncPC, Read, and_strobe;
  logic [31:0] Mdatain = '0;
  logic [4:0]  operation = '0;
  logic [31:0] encoder_input;

  int checks = 0;
  int errors = 0;

  datapath_two_reg #(.WIDTH(32)) dut (
    .Clock(Clock), .Clear(Clear),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
    .R2out(rout[2]), .R6out(rout[6]), .R0out(rout[0]), .R1out(rout[1]),
    .R3out(rout[3]), .R4out(rout[4]), .R5out(rout[5]), .R7out(rout[7]),
    .R8out(rout[8]), .R9out(rout[9]), .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
    .LOout(LOout), .HIout(HIout), .Cout(Cout), .InPortout(InPortout),
    .MARin(MARin), .Zlowin(Zlowin), .Zhighin(Zhighin), .PCin(PCin), .MDRin(MDRin),
    .IRin(IRin), .Yin(Yin), .R2in(R2in), .R6in(R6in), .LOin(LOin), .HIin(HIin),
    .IncPC(IncPC), .Read(Read), .AND(and_strobe), .Mdatain(Mdatain),
    .operation(operation), .encoder_input(encoder_input)
  );

  always #5 Clock = ~Clock;

  initial begin
    #2_000_000;
    $display("FAIL timeout observed no-finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    {PCout, Zlowout, Zhighout, MDRout, LOout, HIout, Cout, InPortout} = '0;
    rout = '0;
    {MARin, Zlowin, Zhighin, PCin, MDRin, IRin, Yin, R2in, R6in, LOin, HIin} = '0;
    {IncPC, Read, and_strobe} = '0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    idle();
  endtask

  task automatic put_mdr(input logic [31:0] v);
    Mdatain = v; Read = 1; MDRin = 1;
    tick();
  endtask

  task automatic set_y(input logic [31:0] v);
    put_mdr(v);
    MDRout = 1; Yin = 1;
    tick();
  endtask

  task automatic alu_z(input logic [31:0] av, input logic [31:0] bv, input logic [4:0] op,
                       input logic lo_en, input logic hi_en);
    set_y(av);
    put_mdr(bv);
    MDRout = 1; operation = op; Zlowin = lo_en; Zhighin = hi_en;
    tick();
  endtask

  function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [31:0] av,
                                           input logic [31:0] bv);
    int          sa = av;
    int          sb = bv;
    int unsigned s  = bv[4:0];
    int          q, r;
    logic [31:0] t;
    case (op)
      5'd3:  return {32'h0, av + bv};
      5'd4:  return {32'h0, av - bv};
      5'd5:  return {32'h0, av & bv};
      5'd6:  return {32'h0, av | bv};
      5'd7:  begin t = (av >> s) | (av << (32 - s)); return {32'h0, t}; end
      5'd8:  begin t = (av << s) | (av >> (32 - s)); return {32'h0, t}; end
      5'd9:  return {32'h0, av >> s};
      5'd10: begin q = sa >>> s; return {32'h0, q}; end
      5'd11: return {32'h0, av << s};
      5'd14: return longint'(sa) * longint'(sb);
      5'd15: begin
        if (bv == 0) return {av, 32'hFFFF_FFFF};
        if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sa / sb;
        r = sa - q * sb;
        return {r, q};
      end
      5'd16: return {32'h0, 32'h0 - bv};
      5'd17: return {32'h0, ~bv};
      default: return 64'h0;
    endcase
  endfunction

  logic [4:0] ops [14] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                           5'd14, 5'd15, 5'd16, 5'd17, 5'd0};

  initial begin
    logic [31:0] ra, rb;
    logic [4:0]  rop;
    idle();
    #2 Clear = 0;
    #1;
    check("reset_r2", {32'h0, dut.r2}, 64'h0);
    check("reset_pc", {32'h0, dut.pc}, 64'h0);
    check("reset_z", dut.z, 64'h0);
    check("reset_enc", {32'h0, encoder_input}, 64'h0);
    @(negedge Clock);
    Clear = 1;
    tick();

    put_mdr(32'h24); MDRout = 1; R2in = 1; tick();
    put_mdr(32'h22); MDRout = 1; R6in = 1; tick();
    check("load_r2", {32'h0, dut.r2}, 64'h24);
    check("load_r6", {32'h0, dut.r6}, 64'h22);
    rout[2] = 1; Yin = 1; tick();
    rout[6] = 1; operation = 5'b01111; Zlowin = 1; Zhighin = 1; tick();
    check("div_z", dut.z, 64'h0000_0002_0000_0001);
    Zlowout = 1; LOin = 1; tick();
    Zhighout = 1; HIin = 1; tick();
    check("div_lo", {32'h0, dut.lo}, 64'h1);
    check("div_hi", {32'h0, dut.hi}, 64'h2);

    PCout = 1; MDRout = 1; MARin = 1; #1;
    check("prio_enc", {32'h0, encoder_input}, 64'h0030_0000);
    check("prio_bus_pc0", {32'h0, dut.bus}, 64'h0);
    tick();
    check("mar_pc", {32'h0, dut.mar}, 64'h0);
    PCin = 1; IncPC = 1; tick();
    check("pc_inc", {32'h0, dut.pc}, 64'h1);
    PCout = 1; MDRout = 1; #1;
    check("prio_bus_pc1", {32'h0, dut.bus}, 64'h1);
    tick();
    put_mdr(32'h2A2B_8000); MDRout = 1; IRin = 1; tick();
    check("ir_load", {32'h0, dut.ir}, 64'h2A2B_8000);

    alu_z(32'hFFFF_FFFE, 32'h3, 5'b01110, 1, 1);
    check("mul_neg", dut.z, 64'hFFFF_FFFF_FFFF_FFFA);
    alu_z(32'hFFFF_FFF9, 32'h2, 5'b01111, 1, 1);
    Zlowout = 1; LOin = 1; tick();
    Zhighout = 1; HIin = 1; tick();
    check("divneg_lo", {32'h0, dut.lo}, 64'hFFFF_FFFD);
    check("divneg_hi", {32'h0, dut.hi}, 64'hFFFF_FFFF);
    alu_z(32'h5, 32'h0, 5'b01111, 1, 1);
    check("div_zero", dut.z, 64'h0000_0005_FFFF_FFFF);
    alu_z(32'h8000_0000, 32'hFFFF_FFFF, 5'b01111, 1, 1);
    check("div_ovf", dut.z, 64'h0000_0000_8000_0000);
    alu_z(32'hFFFF_FFFF, 32'h2, 5'b01110, 1, 0);
    check("zlow_only", dut.z, 64'h0000_0000_FFFF_FFFE);
    MDRout = 1; operation = 5'b01110; Zhighin = 1; tick();
    check("zhigh_only", dut.z, 64'hFFFF_FFFF_FFFF_FFFE);

    put_mdr(32'h0004_0000); MDRout = 1; IRin = 1; tick();
    Cout = 1; R2in = 1; #1;
    check("cout_bus", {32'h0, dut.bus}, 64'hFFFC_0000);
    tick();
    check("cout_r2", {32'h0, dut.r2}, 64'hFFFC_0000);
    rout[2] = 1; rout[6] = 1; #1;
    check("r2_beats_r6_enc", {32'h0, encoder_input}, 64'h44);
    check("r2_beats_r6_bus", {32'h0, dut.bus}, 64'hFFFC_0000);
    tick();
    rout[6] = 1; MDRin = 1; Read = 0; Mdatain = 32'hDEAD_BEEF; tick();
    check("mdr_from_bus", {32'h0, dut.mdr}, 64'h22);

    put_mdr(32'hFFFF_FFFF); MDRout = 1; PCin = 1; tick();
    check("pc_load", {32'h0, dut.pc}, 64'hFFFF_FFFF);
    IncPC = 1; tick();
    check("incpc_alone", {32'h0, dut.pc}, 64'hFFFF_FFFF);
    PCin = 1; IncPC = 1; tick();
    check("pc_wrap", {32'h0, dut.pc}, 64'h0);

    for (int n = 0; n < 48; n++) begin
      ra  = $urandom();
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
      if (n % 9 == 0) rb = 32'hFFFF_FFFF;
      rop = (n % 8 == 7) ? 5'($urandom_range(0, 31)) : ops[$urandom_range(0, 13)];
      alu_z(ra, rb, rop, 1, 1);
      check($sformatf("rand_op%0d", rop), dut.z, ref_alu(rop, ra, rb));
    end

    put_mdr(32'h5A5A_1234);
    MDRout = 1; {R2in, R6in, HIin, LOin, IRin, Yin, PCin, MARin} = '1; tick();
    MDRout = 1; operation = 5'b01110; Zlowin = 1; Zhighin = 1; tick();
    MDRout = 1; operation = 5'b10001; #2;
    Clear = 0; #1;
    check("clr_regs", {dut.r2 | dut.r6 | dut.hi | dut.lo | dut.ir,
                       dut.y | dut.pc | dut.mar | dut.mdr}, 64'h0);
    check("clr_z", dut.z, 64'h0);
    check("clr_alu_live", dut.c, 64'h0000_0000_FFFF_FFFF);
    Clear = 1;
    tick();
    rout[4] = 1; #1;
    check("r4_bus", {32'h0, dut.bus}, 64'h0);
    check("r4_enc", {32'h0, encoder_input}, 64'h10);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/datapath_two_reg.md
Name: datapath_two_reg

Overview:
- Single-bus 32-bit CPU datapath slice: one shared bus; a one-hot out-select encoder chooses the bus driver.
- Contains two general registers (R2, R6), HI, LO, IR, Y, PC, MAR, MDR, a 64-bit Z register and a combinational ALU (including signed mul/div).
- Driven externally by a control sequencer (testbench or control unit) that asserts per-cycle in/out strobes.

Parameters:
- WIDTH, 32, datapath/bus width.

Ports:
- Clock  in  1  rising-edge clock for all registers.
- Clear  in  1  asynchronous, active-low reset; clears every register to 0.
- PCout, Zlowout, Zhighout, MDRout, R2out, R6out  in  1 each  bus-drive selects.
- R0out, R1out, R3out, R4out, R5out, R7out..R15out, LOout, HIout, Cout, InPortout  in  1 each  bus-drive selects.
- MARin, Zlowin, Zhighin, PCin, MDRin, IRin, Yin, R2in, R6in, LOin, HIin  in  1 each  register load enables.
- IncPC  in  1  PC increment qualifier.
- Read  in  1  MDR source select (1 = Mdatain, 0 = bus).
- AND  in  1  reserved strobe; accepted, no effect.
- Mdatain  in  32  memory read data.
- operation  in  5  ALU opcode.
- encoder_input  out  32  one-hot out-select vector fed to the bus encoder.

Behaviour:
- encoder_input bit map:
  - [15:0] R0out..R15out
  - 16 HIout, 17 LOout, 18 Zhighout, 19 Zlowout, 20 PCout, 21 MDRout, 22 InPortout, 23 Cout
  - [31:24] = 0
- Encoder gives a 5-bit index. The lowest-numbered asserted bit wins (e.g. PCout beats MDRout).
- Bus = 0 when no bit is asserted.
- Bus sources:
  - R2 and R6 are real registers; other R-selects and InPortout drive 0.
  - Cout drives sign-extended IR[18:0].
  - Zhighout drives Z[63:32]; Zlowout drives Z[31:0].
- Registers: rising-edge, asynchronous clear to 0 when Clear=0.
  - R2, R6, HI, LO, IR, Y and MAR load the bus when their enable is high.
- MDR: when MDRin, loads Mdatain if Read=1, else the bus.
- PC:
  - PCin & IncPC: PC <= PC+1, wrapping at 0xFFFFFFFF to 0.
  - PCin only: PC <= bus.
  - IncPC alone: no change.
- ALU: combinational. A = Y, B = bus, result C is 64-bit.
- Z: Zlowin loads C[31:0] into Z[31:0]; Zhighin loads C[63:32] into Z[63:32]. Both may load in the same cycle.
- Opcodes; C[63:32]=0 unless stated:
  - 00011 add; 00100 sub (A-B); 00101 and; 00110 or.
  - 00111 ror; 01000 rol; 01001 shr (logical); 01010 shra; 01011 shl. All shift/rotate amounts are B[4:0].
  - 01110 mul: signed 64-bit A*B.
  - 01111 div: signed, truncates toward zero. C[31:0] = quotient, C[63:32] = remainder; remainder takes the sign of the dividend.
  - 10000 neg: -B.
  - 10001 not: ~B.
  - Any other code: C = 0.
- Div by zero: quotient 0xFFFFFFFF, remainder = A.
- 0x80000000 / -1: quotient 0x80000000, remainder 0.
- Overflow in add/sub/neg wraps modulo 2^32, with no flags.
- Reset mid-operation: all registers return to 0 immediately; the combinational ALU still evaluates.

Test Plan:
- Load R2=0x24 and R6=0x22 via Mdatain/Read/MDRin, then MDRout->R2in/R6in. Then R2out+Yin; then R6out, operation=01111, Zlowin+Zhighin; then Zlowout->LOin and Zhighout->HIin -> LO=0x00000001, HI=0x00000002.
- PC=0 with PCout+MDRout both high -> bus=PC, MAR=0. Next PCin+IncPC -> PC=1. Then Mdatain=0x2A2B8000, Read+MDRin, then MDRout+IRin -> IR=0x2A2B8000.
- Y=0xFFFFFFFE, bus=3, mul -> Z=0xFFFFFFFF_FFFFFFFA. Then Y=-7, bus=2, div -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Y=5, bus=0, div -> Zlow=0xFFFFFFFF, Zhigh=0x00000005. Cout with IR[18:0]=0x40000 -> bus=0xFFFC0000.
- Load all registers non-zero, pulse Clear low between clock edges -> every register reads 0 immediately. Assert R4out -> bus=0, encoder_input=0x00000010.
